// File: rtl/arb_pkg.sv
// Shared constants, state type and round-robin pick helper for the arb_rr8 slice.
package arb_pkg;

    localparam int unsigned N_REQ              = 8;
    localparam int unsigned IDX_W              = 3;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 16;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Rotate req so that bit 0 is the ptr position, take the lowest set bit,
    // then add ptr back; the 3-bit sum wraps 7->0 naturally.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [IDX_W-1:0] ptr);
        logic [2*N_REQ-1:0] dbl;
        logic [N_REQ-1:0]   rot;
        logic [IDX_W-1:0]   off;
        dbl = {req, req} >> ptr;
        rot = dbl[N_REQ-1:0];
        off = '0;
        for (int unsigned i = N_REQ; i > 0; i--) begin
            if (rot[i-1]) off = IDX_W'(i - 1);
        end
        return ptr + off;
    endfunction

endpackage

// File: rtl/onehot_enc8.sv
// One-hot to binary encoder for the arbiter grant; output forced to 0 when en is low.
module onehot_enc8 (
    input  logic [7:0] a,
    input  logic       en,
    output logic [2:0] y
);

    always_comb begin
        y = '0;
        if (en) begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (a[i]) y = y | 3'(i);
            end
        end
    end

endmodule

// File: rtl/arb_rr8.sv
// 8-way round-robin arbiter with grant hold until done or request drop.
// Optional forced release after TIMEOUT_CYCLES busy cycles when ARB_TIMEOUT_EN is defined.
module arb_rr8
    import arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    arb_state_e       state, state_nxt;
    logic [N_REQ-1:0] grant_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic             timeout_nxt;
    logic             expired;
    logic             held_req;

    assign gnt_valid = (state == BUSY);
    assign held_req  = req[gnt_idx];

    onehot_enc8 u_enc (
        .a  (grant),
        .en (gnt_valid),
        .y  (gnt_idx)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt;

    // cnt holds (busy cycle number - 1); it is cleared while idle so it starts at 0 on entry.
    assign expired = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              cnt <= '0;
        else if (state == IDLE)  cnt <= '0;
        else                     cnt <= cnt + 1'b1;
    end
`else
    // Parameter kept for interface compatibility; unused in this build.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign expired            = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            grant   <= '0;
            ptr     <= '0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            ptr     <= ptr_nxt;
            timeout <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        ptr_nxt     = ptr;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                grant_nxt = '0;
                if (|req) begin
                    grant_nxt = N_REQ'(1) << rr_pick(req, ptr);
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (done || !held_req || expired) begin
                    grant_nxt   = '0;
                    state_nxt   = IDLE;
                    ptr_nxt     = gnt_idx + 1'b1;
                    // A natural release on the same edge wins over the forced one.
                    timeout_nxt = expired && !done && held_req;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

endmodule
